// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 stream mux, packet-aware round-robin or fixed-select.
// Ports: clk/rst; mode, fixed_sel; in_valid/in_ready/in_data/in_last per
// channel; out_valid/out_ready/out_data/out_last/out_ch registered; busy.
module rr_stream_mux #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         fixed_sel,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    logic [0:0]        state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  lock_ch;
    logic [SEL_W-1:0]  win;
    logic [SEL_W-1:0]  cur_ch;
    logic              win_ok;
    logic              grant_ok;
    logic              can_load;
    logic              xfer;
    logic              cur_last;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] sel_oh;
    logic [DATA_W-1:0] cur_data;

    // Out-of-range fixed_sel leaves the eligible set empty.
    always_comb begin
        elig = '1;
        if (mode) begin
            elig = (int'(fixed_sel) < NUM_CH) ? (ONE << fixed_sel) : '0;
        end
    end

    assign cand = elig & in_valid;

    // Scan ptr+1 .. ptr+NUM_CH with wrap; first hit wins.
    always_comb begin
        int idx;
        win    = '0;
        win_ok = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!win_ok && cand[SEL_W'(idx)]) begin
                win_ok = 1'b1;
                win    = SEL_W'(idx);
            end
        end
    end

    assign cur_ch   = (state == LOCKED) ? lock_ch : win;
    assign grant_ok = (state == LOCKED) || win_ok;
    assign can_load = !out_valid || out_ready;
    assign sel_oh   = ONE << cur_ch;
    assign cur_data = in_data[int'(cur_ch)*DATA_W +: DATA_W];
    assign cur_last = in_last[cur_ch];

    assign in_ready = (!rst && grant_ok && can_load) ? sel_oh : '0;
    assign xfer     = !rst && grant_ok && can_load && in_valid[cur_ch];
    assign busy     = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= cur_data;
            out_last  <= cur_last;
            out_ch    <= cur_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= SEL_W'(NUM_CH - 1);
            lock_ch <= '0;
        end else if (xfer) begin
            unique case (1'b1)
                (state == IDLE) && cur_last: begin
                    ptr <= cur_ch;
                end
                (state == IDLE) && !cur_last: begin
                    state   <= LOCKED;
                    lock_ch <= cur_ch;
                end
                (state == LOCKED) && cur_last: begin
                    state <= IDLE;
                    ptr   <= lock_ch;
                end
                default: ;
            endcase
        end
    end

endmodule
